ring_freq_meter: RTL and testbench
==================================

Name: ring_freq_meter

Overview:
- Measures the divided ring-oscillator output (divider's slowest tap) against the system clock.
- Counts rising edges of the asynchronous oscillator input over a programmable gate window of system-clock cycles.
- Presents the result through a valid/ack handshake, for readout on chip outputs or by a host.
- Sits between the ring divider macro and the top-level output mux.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the osc_in synchronizer (min 2).
- CNT_W, 16, width of the edge-count result.
- GATE_W, 16, width of the gate-window counter; must hold 2^(GATE_BASE_LOG2+7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- osc_in  in  1  divided oscillator signal, asynchronous to clk.
- start  in  1  request one measurement; sampled in IDLE only.
- continuous  in  1  when 1, re-arm automatically after each ack.
- gate_sel  in  3  gate window = 2^(GATE_BASE_LOG2 + gate_sel) clk cycles.
- ack  in  1  consumer accepts result; meaningful only while valid=1.
- count  out  CNT_W  rising-edge count of last completed window.
- overflow  out  1  last window saturated count.
- valid  out  1  result available.
- busy  out  1  measurement in ARM or COUNT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; count=0, overflow=0, valid=0, busy=0; synchronizer, edge history, gate counter and edge counter all cleared.
- osc_in passes through SYNC_STAGES flops, then a one-flop history register. A rising edge is synchronized value 1 while history is 0.

State machine:
- IDLE
  - start=1 -> ARM.
  - Otherwise stay.
- ARM (1 cycle)
  - Latch gate_sel.
  - Clear edge counter and gate counter.
  - Load history with the current synchronized value, so a high level at arm time is not counted.
  - -> COUNT.
- COUNT (exactly N = 2^(GATE_BASE_LOG2+gate_sel_latched) cycles)
  - Each cycle with a detected rising edge increments the edge counter.
  - The edge counter saturates at 2^CNT_W-1; an edge arriving at saturation sets an internal ovf flag.
  - Gate counter increments every cycle. After the Nth cycle -> DONE.
- DONE
  - Entry cycle: count<=edge counter, overflow<=ovf, valid<=1.
  - Hold while valid=1 and ack=0.
  - On ack=1: valid<=0; next state is ARM if continuous=1, else IDLE.
- busy=1 exactly in ARM and COUNT.

Latency:
- start sampled at edge t -> ARM during t+1, COUNT during t+2..t+N+1.
- valid rises at edge t+N+2.
- The synchronizer shifts the effective window by SYNC_STAGES cycles; this is accepted.

Boundary rules:
- start while busy or valid: ignored.
- gate_sel changes during COUNT: ignored (latched value used).
- ack while valid=0: ignored.
- ack in the same cycle valid first rises: not possible, since valid is registered; ack is sampled from the following cycle.
- continuous deasserted while busy: the current window completes; no re-arm after its ack.
- Reset mid-COUNT or mid-DONE: immediate return to reset values; the partial result is discarded.
- count/overflow are stable from valid rise until the next DONE entry.

Decomposition:
- Package ring_meter_pkg:
  - State enum (IDLE, ARM, COUNT, DONE).
  - GATE_BASE_LOG2 = 8.
  - Gate-length helper function.
- Sub-module ring_edge_sync: parameterised SYNC_STAGES synchronizer plus history flop, with a one-cycle rise pulse output and a prime input used in ARM.
- FSM, counters and result registers live in ring_freq_meter.

Test Plan:
- Reset values: reset asserted mid-COUNT with osc toggling -> count=0, overflow=0, valid=0, busy=0 immediately; after release, state IDLE and busy stays 0.
- Basic count and latency: osc period 8 clk, gate_sel=0, start pulse at edge t -> busy high t+1..t+257, valid at t+258, count=32, overflow=0.
- Window scaling: same osc, gate_sel=2 (1024 cycles) -> count=128; gate_sel changed to 0 during COUNT -> count still 128.
- Saturation: CNT_W=4, osc period 4, gate_sel=0 -> 64 edges, count=15, overflow=1.
- Handshake and continuous:
  - continuous=1, ack withheld 50 cycles -> valid held, count stable, no new window.
  - ack -> valid drops next cycle, busy rises, next result valid 258 cycles after ack.
- Ignore rules and held-high osc:
  - start pulsed during COUNT -> no extra measurement.
  - osc_in held high from before start -> count=0.

Source files
------------

// File: rtl/ring_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM state
// encoding, the base gate length and the gate-length helper.
package ring_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } meter_state_t;

    // Shortest gate window is 2^GATE_BASE_LOG2 system-clock cycles.
    localparam int GATE_BASE_LOG2 = 8;

    // Width of the gate window selector.
    localparam int GATE_SEL_W = 3;

    // Number of clk cycles in the gate window selected by sel.
    function automatic logic [31:0] gate_len(input logic [GATE_SEL_W-1:0] sel);
        int shift_amt;
        shift_amt = GATE_BASE_LOG2 + int'(sel);
        gate_len  = 32'd1 << shift_amt;
    endfunction

    // Terminal value of a gate counter that starts at zero for window sel.
    function automatic logic [31:0] gate_last(input logic [GATE_SEL_W-1:0] sel);
        gate_last = gate_len(sel) - 32'd1;
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the asynchronous divided oscillator into the clk domain and turns
// its rising edges into single-cycle pulses. The history flop tracks the
// synchronized level every cycle, so loading it at arm time is implicit;
// prime additionally blanks the pulse for that cycle so a level that is
// already high when a window is armed never produces a count.
module ring_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_in,
    input  logic prime,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   sync_top_s;

    assign sync_top_s = sync_r[SYNC_STAGES-1];

    // Metastability chain: osc_in enters at bit 0 and moves toward the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], osc_in};
        end
    end

    // History flop: previous synchronized level, reloaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 1'b0;
        end else begin
            hist_r <= sync_top_s;
        end
    end

    // Rise pulse: synchronized high while history is low, masked while priming.
    always_comb begin
        rise = 1'b0;
        if (prime) begin
            rise = 1'b0;
        end else begin
            rise = sync_top_s & ~hist_r;
        end
    end

endmodule

// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of
// osc_in over a gate window of 2^(GATE_BASE_LOG2+gate_sel) clk cycles and
// presents the result with a valid/ack handshake. The edge count saturates
// and flags overflow; continuous mode re-arms after every acknowledge.
module ring_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    input  logic [2:0]       gate_sel,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    meter_state_t            state_r;
    logic [GATE_SEL_W-1:0]   gate_sel_r;
    logic [GATE_W-1:0]       gate_cnt_r;
    logic [CNT_W-1:0]        edge_cnt_r;
    logic                    ovf_r;
    logic [CNT_W-1:0]        count_r;
    logic                    overflow_r;
    logic                    valid_r;
    logic                    busy_r;

    logic                    rise_s;
    logic                    prime_s;
    logic [GATE_W-1:0]       gate_last_s;

    assign prime_s     = (state_r == ARM);
    assign gate_last_s = GATE_W'(gate_last(gate_sel_r));

    assign count    = count_r;
    assign overflow = overflow_r;
    assign valid    = valid_r;
    assign busy     = busy_r;

    ring_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .prime  (prime_s),
        .rise   (rise_s)
    );

    // Measurement sequencer with gate/edge counters and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gate_sel_r <= '0;
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
            ovf_r      <= 1'b0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= ARM;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                ARM: begin
                    // The window length is frozen here; later gate_sel
                    // changes only affect the next arm.
                    gate_sel_r <= gate_sel;
                    gate_cnt_r <= '0;
                    edge_cnt_r <= '0;
                    ovf_r      <= 1'b0;
                    state_r    <= COUNT;
                    busy_r     <= 1'b1;
                end

                COUNT: begin
                    if (rise_s) begin
                        if (edge_cnt_r == CNT_MAX) begin
                            ovf_r <= 1'b1;
                        end else begin
                            edge_cnt_r <= edge_cnt_r + CNT_ONE;
                        end
                    end else begin
                        edge_cnt_r <= edge_cnt_r;
                    end
                    gate_cnt_r <= gate_cnt_r + GATE_ONE;
                    if (gate_cnt_r == gate_last_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= COUNT;
                        busy_r  <= 1'b1;
                    end
                end

                DONE: begin
                    // valid is low only on the entry cycle, since leaving
                    // DONE and dropping valid happen on the same edge.
                    if (!valid_r) begin
                        count_r    <= edge_cnt_r;
                        overflow_r <= ovf_r;
                        valid_r    <= 1'b1;
                    end else if (ack) begin
                        valid_r <= 1'b0;
                        if (continuous) begin
                            state_r <= ARM;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Self-checking bench for ring_freq_meter: a table of directed windows,
// hand-written handshake/reset sequences and randomized oscillator patterns
// checked against an edge-counting reference model over a logged osc trace.
module tb_ring_freq_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [2:0]  gate_sel = 3'd0;
    logic        ack = 1'b0;

    logic [15:0] count16;
    logic        ovf16, valid16, busy16;
    logic [3:0]  count4;
    logic        ovf4, valid4, busy4;

    int nvec = 0;
    int nmis = 0;
    int edge_no = 0;
    bit osc_log [0:199999];

    int osc_period = 8;
    int osc_high   = 4;
    int osc_phase  = 0;
    bit osc_hold   = 1'b0;
    bit osc_level  = 1'b0;
    bit osc_rand   = 1'b0;

    typedef struct {
        logic [2:0] gs;
        int         period;
        bit         hold;
        int         exp16;
        int         exp4;
        int         expovf4;
    } vec_t;

    ring_freq_meter #(.SYNC_STAGES(S), .CNT_W(16), .GATE_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start),
        .continuous(continuous), .gate_sel(gate_sel), .ack(ack),
        .count(count16), .overflow(ovf16), .valid(valid16), .busy(busy16)
    );

    ring_freq_meter #(.SYNC_STAGES(S), .CNT_W(4), .GATE_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start),
        .continuous(continuous), .gate_sel(gate_sel), .ack(ack),
        .count(count4), .overflow(ovf4), .valid(valid4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Log osc_in as seen at every rising clk edge (edge index = edge_no).
    initial begin
        forever begin
            @(posedge clk);
            osc_log[edge_no] = osc_in;
            edge_no++;
        end
    end

    // Oscillator generator, changes only on the falling clk edge.
    initial begin
        forever begin
            @(negedge clk);
            if (osc_hold) osc_in = osc_level;
            else if (osc_rand) osc_in = 1'($urandom_range(0, 1));
            else osc_in = (((edge_no + osc_phase) % osc_period) < osc_high);
        end
    end

    // Reference: rising edges of osc seen through S synchronizer flops,
    // counted in the N cycles following the arm cycle at edge t.
    function automatic int model_edges(input int t, input int n);
        int c = 0;
        for (int e = t + 1; e <= t + n; e++) begin
            if (e - S >= 0 && osc_log[e-S+1] && !osc_log[e-S]) c++;
        end
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_result(input int exp);
        chk("count16", int'(count16), exp);
        chk("ovf16", int'(ovf16), 0);
        chk("count4", int'(count4), (exp > 15) ? 15 : exp);
        chk("ovf4", int'(ovf4), (exp > 15) ? 1 : 0);
        chk("valid4", int'(valid4), 1);
    endtask

    // One measurement from IDLE; disturb pulses start and flips gate_sel mid-COUNT.
    task automatic measure(input logic [2:0] gs, input bit disturb, output int t0);
        int n;
        int e;
        bit ok;
        n  = 1 << (8 + int'(gs));
        ok = 1'b0;
        @(negedge clk);
        gate_sel = gs;
        start    = 1'b1;
        t0       = edge_no;
        for (int i = 0; i < n + 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = edge_no - 1;
            if (disturb && e == t0 + 100) begin
                gate_sel = ~gs;
                start    = 1'b1;
            end
            if (valid16) begin
                chk("valid_latency", e, t0 + n + 2);
                ok = 1'b1;
                break;
            end
            chk("busy", int'(busy16), (e >= t0 && e <= t0 + n) ? 1 : 0);
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_ack(output int a);
        @(negedge clk);
        ack = 1'b1;
        a   = edge_no;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_drop", int'(valid16), 0);
        chk("busy_after_ack", int'(busy16), int'(continuous));
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_busy", int'(busy16), 0);
            chk("idle_valid", int'(valid16), 0);
        end
    endtask

    initial begin
        vec_t tbl [7];
        int   t0;
        int   a;
        int   e;
        int   c0;
        int   exp;
        bit   ok;
        logic [2:0] gs;

        tbl[0] = '{3'd0, 8,  1'b0, 32,  15, 1};
        tbl[1] = '{3'd2, 8,  1'b0, 128, 15, 1};
        tbl[2] = '{3'd0, 4,  1'b0, 64,  15, 1};
        tbl[3] = '{3'd0, 8,  1'b1, 0,   0,  0};
        tbl[4] = '{3'd0, 32, 1'b0, 8,   8,  0};
        tbl[5] = '{3'd0, 16, 1'b0, 16,  15, 1};
        tbl[6] = '{3'd1, 64, 1'b0, 8,   8,  0};

        repeat (5) @(negedge clk);
        chk("rst_count", int'(count16), 0);
        chk("rst_valid", int'(valid16), 0);
        chk("rst_busy", int'(busy16), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ack while nothing is valid has no effect
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        idle_check(5);

        // directed windows with mid-window start/gate_sel disturbance
        for (int v = 0; v < 7; v++) begin
            osc_rand   = 1'b0;
            osc_period = tbl[v].period;
            osc_high   = tbl[v].period / 2;
            osc_phase  = v;
            osc_hold   = tbl[v].hold;
            osc_level  = 1'b1;
            repeat (10) @(negedge clk);
            measure(tbl[v].gs, 1'b1, t0);
            chk("tbl_count16", int'(count16), tbl[v].exp16);
            chk("tbl_ovf16", int'(ovf16), 0);
            chk("tbl_count4", int'(count4), tbl[v].exp4);
            chk("tbl_ovf4", int'(ovf4), tbl[v].expovf4);
            do_ack(a);
            idle_check(20);
        end
        osc_hold = 1'b0;

        // continuous mode: result held while ack withheld, then re-arm
        osc_period = 8;
        osc_high   = 4;
        continuous = 1'b1;
        repeat (10) @(negedge clk);
        measure(3'd0, 1'b0, t0);
        chk("cont_count", int'(count16), 32);
        c0 = int'(count16);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(valid16), 1);
            chk("hold_count", int'(count16), c0);
            chk("hold_busy", int'(busy16), 0);
        end
        do_ack(a);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            e = edge_no - 1;
            if (i == 50) continuous = 1'b0;
            if (valid16) begin
                chk("rearm_latency", e, a + 258);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rearm_timeout", 0, 1);
        chk_result(model_edges(a, 256));
        chk("rearm_count", int'(count16), 32);
        do_ack(a);
        idle_check(20);

        // randomized oscillator patterns against the reference model
        for (int r = 0; r < 16; r++) begin
            osc_rand   = ($urandom_range(0, 3) == 0);
            osc_period = $urandom_range(2, 24);
            osc_high   = $urandom_range(1, osc_period - 1);
            osc_phase  = $urandom_range(0, 31);
            gs         = 3'($urandom_range(0, 1));
            repeat ($urandom_range(3, 12)) @(negedge clk);
            measure(gs, 1'b0, t0);
            exp = model_edges(t0, 1 << (8 + int'(gs)));
            chk_result(exp);
            do_ack(a);
        end
        osc_rand = 1'b0;

        // reset in the middle of COUNT discards everything
        osc_period = 8;
        osc_high   = 4;
        @(negedge clk);
        gate_sel = 3'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_busy", int'(busy16), 1);
        rst_n = 1'b0;
        #1;
        chk("midcnt_rst_count16", int'(count16), 0);
        chk("midcnt_rst_ovf16", int'(ovf16), 0);
        chk("midcnt_rst_valid", int'(valid16), 0);
        chk("midcnt_rst_busy", int'(busy16), 0);
        chk("midcnt_rst_ovf4", int'(ovf4), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check(20);

        // reset while a result is pending
        measure(3'd0, 1'b0, t0);
        chk("pre_rst_valid", int'(valid16), 1);
        rst_n = 1'b0;
        #1;
        chk("done_rst_valid", int'(valid16), 0);
        chk("done_rst_count", int'(count16), 0);
        chk("done_rst_ovf4", int'(ovf4), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check(10);

        // recovery after reset
        measure(3'd0, 1'b0, t0);
        chk_result(model_edges(t0, 256));
        chk("recover_count", int'(count16), 32);
        do_ack(a);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
